// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencing controller for the 5-stage core: stalls, flushes,
// memory-wait handling and debug counters.
module pipe_hazard_ctrl #(
  parameter int CNT_W    = 16,
  parameter int WAIT_MAX = 255
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             IDEX_MemRead,
  input  logic [4:0]       IDEX_Rt,
  input  logic [4:0]       IFID_Rs,
  input  logic [4:0]       IFID_Rt,
  input  logic             EX_BranchTaken,
  input  logic             MEM_Req,
  input  logic             MEM_Ready,
  output logic             PC_En,
  output logic             IFID_En,
  output logic             IDEX_En,
  output logic             EXMEM_En,
  output logic             MEMWB_En,
  output logic             IFID_Flush,
  output logic             IDEX_Bubble,
  output logic             MEMWB_Bubble,
  output logic [CNT_W-1:0] Stall_Cnt,
  output logic [CNT_W-1:0] Flush_Cnt,
  output logic             Mem_Timeout
);

  typedef enum logic {
    RUN,
    MEM_WAIT
  } state_t;

  typedef struct packed {
    logic pc;
    logic ifid;
    logic idex;
    logic exmem;
    logic memwb;
    logic ifid_flush;
    logic idex_bubble;
    logic memwb_bubble;
  } ctrl_t;

  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [15:0]      WAIT_TOP = 16'(WAIT_MAX);
  localparam logic [15:0]      WCNT_MAX = '1;

  state_t state;
  state_t state_nxt;
  ctrl_t  ctrl;

  logic mem_stall;
  logic advance;
  logic load_use;
  logic wait_tick;

  logic [15:0]      wait_cnt;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;
  logic             timeout;

  always_comb begin
    mem_stall = 1'b0;
    unique case (state)
      RUN:      mem_stall = MEM_Req & ~MEM_Ready;
      MEM_WAIT: mem_stall = ~MEM_Ready;
      default:  mem_stall = 1'b0;
    endcase
    advance   = ~mem_stall;
    wait_tick = (state == MEM_WAIT) & ~MEM_Ready;
  end

  always_comb begin
    load_use = IDEX_MemRead
             & (IDEX_Rt != 5'd0)
             & ((IDEX_Rt == IFID_Rs)
             | (IDEX_Rt == IFID_Rt));
  end

  // Memory stall outranks branch, branch outranks load-use.
  always_comb begin
    ctrl = '{pc: 1'b1, ifid: 1'b1, idex: 1'b1,
             exmem: 1'b1, memwb: 1'b1,
             ifid_flush: 1'b0, idex_bubble: 1'b0,
             memwb_bubble: 1'b0};
    priority case (1'b1)
      reset: begin
        ctrl.pc           = 1'b0;
        ctrl.ifid_flush   = 1'b1;
        ctrl.idex_bubble  = 1'b1;
        ctrl.memwb_bubble = 1'b1;
      end
      mem_stall: begin
        ctrl.pc           = 1'b0;
        ctrl.ifid         = 1'b0;
        ctrl.idex         = 1'b0;
        ctrl.exmem        = 1'b0;
        ctrl.memwb_bubble = 1'b1;
      end
      EX_BranchTaken: begin
        ctrl.ifid_flush  = 1'b1;
        ctrl.idex_bubble = 1'b1;
      end
      load_use: begin
        ctrl.pc          = 1'b0;
        ctrl.ifid        = 1'b0;
        ctrl.idex_bubble = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      RUN:
        if (MEM_Req && !MEM_Ready)
          state_nxt = MEM_WAIT;
      MEM_WAIT:
        if (MEM_Ready || !MEM_Req)
          state_nxt = RUN;
      default:
        state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= RUN;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (!ctrl.pc && stall_cnt != CNT_MAX)
        stall_cnt <= stall_cnt + 1'b1;
      if (advance && EX_BranchTaken
          && flush_cnt != CNT_MAX)
        flush_cnt <= flush_cnt + 1'b1;
    end
  end

  // Flag is raised on the edge where the count reaches WAIT_MAX.
  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt <= '0;
      timeout  <= 1'b0;
    end else begin
      if (state == RUN && state_nxt == MEM_WAIT) begin
        wait_cnt <= '0;
      end else if (wait_tick && wait_cnt != WCNT_MAX) begin
        wait_cnt <= wait_cnt + 16'd1;
      end
      if (wait_tick && wait_cnt >= WAIT_TOP - 16'd1)
        timeout <= 1'b1;
    end
  end

  assign PC_En        = ctrl.pc;
  assign IFID_En      = ctrl.ifid;
  assign IDEX_En      = ctrl.idex;
  assign EXMEM_En     = ctrl.exmem;
  assign MEMWB_En     = ctrl.memwb;
  assign IFID_Flush   = ctrl.ifid_flush;
  assign IDEX_Bubble  = ctrl.idex_bubble;
  assign MEMWB_Bubble = ctrl.memwb_bubble;
  assign Stall_Cnt    = stall_cnt;
  assign Flush_Cnt    = flush_cnt;
  assign Mem_Timeout  = timeout;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Testbench for pipe_hazard_ctrl: directed table, corner sequences and
// randomized traffic against a cycle-level reference model.
module tb_pipe_hazard_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic       IDEX_MemRead;
  logic [4:0] IDEX_Rt;
  logic [4:0] IFID_Rs;
  logic [4:0] IFID_Rt;
  logic       EX_BranchTaken;
  logic       MEM_Req;
  logic       MEM_Ready;

  logic        a_pc, a_ifid, a_idex, a_exmem, a_memwb;
  logic        a_fl, a_bub, a_mbub, a_to;
  logic [15:0] a_sc, a_fc;
  logic        b_pc, b_ifid, b_idex, b_exmem, b_memwb;
  logic        b_fl, b_bub, b_mbub, b_to;
  logic [3:0]  b_sc, b_fc;

  pipe_hazard_ctrl #(.CNT_W(16), .WAIT_MAX(4)) dut_a (
    .clk(clk), .reset(reset),
    .IDEX_MemRead(IDEX_MemRead), .IDEX_Rt(IDEX_Rt),
    .IFID_Rs(IFID_Rs), .IFID_Rt(IFID_Rt),
    .EX_BranchTaken(EX_BranchTaken),
    .MEM_Req(MEM_Req), .MEM_Ready(MEM_Ready),
    .PC_En(a_pc), .IFID_En(a_ifid), .IDEX_En(a_idex),
    .EXMEM_En(a_exmem), .MEMWB_En(a_memwb),
    .IFID_Flush(a_fl), .IDEX_Bubble(a_bub),
    .MEMWB_Bubble(a_mbub),
    .Stall_Cnt(a_sc), .Flush_Cnt(a_fc), .Mem_Timeout(a_to)
  );

  pipe_hazard_ctrl #(.CNT_W(4), .WAIT_MAX(6)) dut_b (
    .clk(clk), .reset(reset),
    .IDEX_MemRead(IDEX_MemRead), .IDEX_Rt(IDEX_Rt),
    .IFID_Rs(IFID_Rs), .IFID_Rt(IFID_Rt),
    .EX_BranchTaken(EX_BranchTaken),
    .MEM_Req(MEM_Req), .MEM_Ready(MEM_Ready),
    .PC_En(b_pc), .IFID_En(b_ifid), .IDEX_En(b_idex),
    .EXMEM_En(b_exmem), .MEMWB_En(b_memwb),
    .IFID_Flush(b_fl), .IDEX_Bubble(b_bub),
    .MEMWB_Bubble(b_mbub),
    .Stall_Cnt(b_sc), .Flush_Cnt(b_fc), .Mem_Timeout(b_to)
  );

  // {pc, ifid, idex, exmem, memwb, ifid_flush, idex_bubble, memwb_bubble}
  localparam logic [7:0] C_RST  = 8'h7F;
  localparam logic [7:0] C_NORM = 8'hF8;
  localparam logic [7:0] C_LU   = 8'h3A;
  localparam logic [7:0] C_BR   = 8'hFE;
  localparam logic [7:0] C_MS   = 8'h09;

  logic [7:0] ctl_a, ctl_b;
  assign ctl_a = {a_pc, a_ifid, a_idex, a_exmem, a_memwb,
                  a_fl, a_bub, a_mbub};
  assign ctl_b = {b_pc, b_ifid, b_idex, b_exmem, b_memwb,
                  b_fl, b_bub, b_mbub};

  int tests = 0;
  int errs  = 0;

  // Reference model: is an access already outstanding, how long it has
  // waited, and the debug counters as plain integers.
  typedef struct {
    bit pend;
    int wcnt;
    bit to;
    int sc;
    int fc;
  } mdl_t;

  mdl_t ma, mb;

  function automatic bit mdl_lu();
    return IDEX_MemRead && IDEX_Rt != 0 &&
           (IDEX_Rt == IFID_Rs || IDEX_Rt == IFID_Rt);
  endfunction

  function automatic bit mdl_stl(mdl_t m);
    return m.pend ? !MEM_Ready : (MEM_Req && !MEM_Ready);
  endfunction

  function automatic logic [7:0] mdl_ctl(mdl_t m);
    if (reset) return C_RST;
    if (mdl_stl(m)) return C_MS;
    if (EX_BranchTaken) return C_BR;
    if (mdl_lu()) return C_LU;
    return C_NORM;
  endfunction

  function automatic mdl_t mdl_next(mdl_t m, int cmax, int wmax);
    mdl_t n = m;
    bit stl;
    logic [7:0] c;
    if (reset) begin
      n = '{0, 0, 0, 0, 0};
      return n;
    end
    stl = mdl_stl(m);
    c = mdl_ctl(m);
    if (!c[7] && n.sc < cmax) n.sc++;
    if (!stl && EX_BranchTaken && n.fc < cmax) n.fc++;
    if (m.pend) begin
      if (!MEM_Ready) begin
        n.wcnt++;
        if (n.wcnt >= wmax) n.to = 1;
      end
      if (MEM_Ready || !MEM_Req) n.pend = 0;
    end else if (stl) begin
      n.pend = 1;
      n.wcnt = 0;
    end
    return n;
  endfunction

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
    end
  endtask

  logic [7:0] s_ctl;
  logic [31:0] s_sc, s_fc, s_bsc;
  logic s_to;

  task automatic step(input bit r, input bit mr,
                      input logic [4:0] xrt,
                      input logic [4:0] rs,
                      input logic [4:0] rt,
                      input bit br, input bit rq, input bit rd);
    @(negedge clk);
    reset = r;
    IDEX_MemRead = mr;
    IDEX_Rt = xrt;
    IFID_Rs = rs;
    IFID_Rt = rt;
    EX_BranchTaken = br;
    MEM_Req = rq;
    MEM_Ready = rd;
    #1;
    s_ctl = ctl_a;
    s_sc  = 32'(a_sc);
    s_fc  = 32'(a_fc);
    s_bsc = 32'(b_sc);
    s_to  = a_to;
    chk("mdl_ctl_a", 32'(ctl_a), 32'(mdl_ctl(ma)));
    chk("mdl_ctl_b", 32'(ctl_b), 32'(mdl_ctl(mb)));
    chk("mdl_stall_a", 32'(a_sc), ma.sc);
    chk("mdl_stall_b", 32'(b_sc), mb.sc);
    chk("mdl_flush_a", 32'(a_fc), ma.fc);
    chk("mdl_flush_b", 32'(b_fc), mb.fc);
    chk("mdl_tout_a", 32'(a_to), 32'(ma.to));
    chk("mdl_tout_b", 32'(b_to), 32'(mb.to));
    @(posedge clk);
    ma = mdl_next(ma, 65535, 4);
    mb = mdl_next(mb, 15, 6);
  endtask

  typedef struct {
    bit r, mr;
    logic [4:0] xrt, rs, rt;
    bit br, rq, rd;
    logic [7:0] ctl;
    int sc, fc;
    bit to;
  } vec_t;

  vec_t tbl[21];

  initial begin
    tbl[0]  = '{1,0,0,0,0,0,0,0, C_RST, 0,0,0};
    tbl[1]  = '{1,0,0,0,0,0,0,0, C_RST, 0,0,0};
    tbl[2]  = '{0,0,0,0,0,0,0,0, C_NORM,0,0,0};
    tbl[3]  = '{0,1,5,5,0,0,0,0, C_LU,  0,0,0};
    tbl[4]  = '{0,0,0,0,0,0,0,0, C_NORM,1,0,0};
    tbl[5]  = '{0,1,0,0,0,0,0,0, C_NORM,1,0,0};
    tbl[6]  = '{0,1,7,1,7,0,0,0, C_LU,  1,0,0};
    tbl[7]  = '{0,1,3,3,0,1,0,0, C_BR,  2,0,0};
    tbl[8]  = '{0,0,0,0,0,0,0,0, C_NORM,2,1,0};
    tbl[9]  = '{0,0,0,0,0,1,1,0, C_MS,  2,1,0};
    tbl[10] = '{0,0,0,0,0,1,1,0, C_MS,  3,1,0};
    tbl[11] = '{0,0,0,0,0,1,1,0, C_MS,  4,1,0};
    tbl[12] = '{0,0,0,0,0,1,1,1, C_BR,  5,1,0};
    tbl[13] = '{0,0,0,0,0,0,0,0, C_NORM,5,2,0};
    tbl[14] = '{0,0,0,0,0,0,1,1, C_NORM,5,2,0};
    tbl[15] = '{0,1,4,4,0,0,1,0, C_MS,  5,2,0};
    tbl[16] = '{0,1,4,4,0,0,1,1, C_LU,  6,2,0};
    tbl[17] = '{0,0,0,0,0,0,0,0, C_NORM,7,2,0};
    tbl[18] = '{0,0,0,0,0,0,1,0, C_MS,  7,2,0};
    tbl[19] = '{0,0,0,0,0,0,0,0, C_MS,  8,2,0};
    tbl[20] = '{0,0,0,0,0,0,0,0, C_NORM,9,2,0};

    reset = 1'b1;
    IDEX_MemRead = 1'b0;
    IDEX_Rt = '0;
    IFID_Rs = '0;
    IFID_Rt = '0;
    EX_BranchTaken = 1'b0;
    MEM_Req = 1'b0;
    MEM_Ready = 1'b0;
    @(posedge clk);
    ma = '{0, 0, 0, 0, 0};
    mb = '{0, 0, 0, 0, 0};

    for (int i = 0; i < 21; i++) begin
      step(tbl[i].r, tbl[i].mr, tbl[i].xrt, tbl[i].rs,
           tbl[i].rt, tbl[i].br, tbl[i].rq, tbl[i].rd);
      chk($sformatf("tbl%0d_ctl", i), 32'(s_ctl), 32'(tbl[i].ctl));
      chk($sformatf("tbl%0d_stall", i), s_sc, tbl[i].sc);
      chk($sformatf("tbl%0d_flush", i), s_fc, tbl[i].fc);
      chk($sformatf("tbl%0d_tout", i), 32'(s_to), 32'(tbl[i].to));
    end

    // Timeout: one RUN stall cycle then five MEM_WAIT cycles.
    step(1,0,0,0,0,0,0,0);
    for (int k = 1; k <= 6; k++) begin
      step(0,0,0,0,0,0,1,0);
      chk($sformatf("tout_wait%0d", k), 32'(s_to),
          (k == 6) ? 32'd1 : 32'd0);
      chk($sformatf("tout_ctl%0d", k), 32'(s_ctl), 32'(C_MS));
    end
    step(0,0,0,0,0,0,1,1);
    chk("tout_ready", 32'(s_to), 32'd1);
    chk("tout_rel_ctl", 32'(s_ctl), 32'(C_NORM));
    step(0,0,0,0,0,0,0,0);
    chk("tout_sticky", 32'(s_to), 32'd1);
    chk("tout_stalls", s_sc, 32'd6);
    step(1,0,0,0,0,0,0,0);
    step(0,0,0,0,0,0,0,0);
    chk("tout_cleared", 32'(s_to), 32'd0);

    // Saturation: 20 load-use stalls.
    for (int k = 0; k < 20; k++)
      step(0,1,9,9,0,0,0,0);
    step(0,0,0,0,0,0,0,0);
    chk("sat_stall_b", s_bsc, 32'd15);
    chk("sat_stall_a", s_sc, 32'd20);

    // Reset while in MEM_WAIT aborts the wait.
    step(0,0,0,0,0,0,1,0);
    step(0,0,0,0,0,0,1,0);
    step(1,0,0,0,0,0,1,0);
    chk("rstw_ctl", 32'(s_ctl), 32'(C_RST));
    step(0,0,0,0,0,0,0,0);
    chk("rstw_run", 32'(s_ctl), 32'(C_NORM));
    chk("rstw_stall", s_sc, 32'd0);
    chk("rstw_stall_b", s_bsc, 32'd0);

    for (int i = 0; i < 3000; i++) begin
      bit r, mr, br, rq, rd;
      logic [4:0] xrt, rs, rt;
      r  = ($urandom_range(0, 99) == 0);
      mr = ($urandom_range(0, 1) == 0);
      br = ($urandom_range(0, 3) == 0);
      rq = ma.pend ? ($urandom_range(0, 19) != 0)
                   : ($urandom_range(0, 3) == 0);
      rd = ($urandom_range(0, 2) == 0);
      xrt = 5'($urandom_range(0, 3));
      rs  = 5'($urandom_range(0, 3));
      rt  = 5'($urandom_range(0, 3));
      step(r, mr, xrt, rs, rt, br, rq, rd);
    end

    $display("[TB] %0d tests run, %0d failed", tests, errs);
    $finish;
  end

endmodule
